// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame pong ball sequencer (serve, move, bounce, score); define SPEEDUP_EN to ramp speed on each paddle hit
module ball_motion_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_RADIUS  = 8,
  parameter int CENTER_X     = 320,
  parameter int CENTER_Y     = 240,
  parameter int SPEED        = 2,
  parameter int MAX_SPEED    = 6,
  parameter int SERVE_FRAMES = 60,
  parameter int PADDLE_X_L   = 16,
  parameter int PADDLE_X_R   = 624,
  parameter int PADDLE_H     = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       stop,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       point_l,
  output logic       point_r,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SERVE, RUN, SCORE} state_t;
  localparam logic [10:0] R      = 11'(BALL_RADIUS);
  localparam logic [10:0] CX     = 11'(CENTER_X);
  localparam logic [10:0] CY     = 11'(CENTER_Y);
  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] MAXS   = 11'(MAX_SPEED);
  localparam logic [10:0] PXL    = 11'(PADDLE_X_L);
  localparam logic [10:0] PXR    = 11'(PADDLE_X_R);
  localparam logic [10:0] PH1    = 11'(PADDLE_H - 1);
  localparam logic [10:0] X_EDGE = 11'(H_ACTIVE - 1);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - 1 - BALL_RADIUS);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - 1 - BALL_RADIUS);
  localparam logic [15:0] SF     = 16'(SERVE_FRAMES);
`ifdef SPEEDUP_EN
  localparam logic [10:0] INC    = 11'd1;
`else
  localparam logic [10:0] INC    = 11'd0;
`endif
  state_t      r_state, w_state;
  logic [10:0] r_x, r_y, r_spd, w_x, w_y, w_spd;
  logic        r_dir_l, r_dir_u, w_dir_l, w_dir_u;
  logic [15:0] r_cnt, w_cnt;
  logic        r_point_l, r_point_r, w_point_l, w_point_r;
  logic [10:0] w_pad_l, w_pad_r, w_spd_up;
  logic        w_top, w_bot, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  assign w_pad_l  = {1'b0, paddle_l_y};
  assign w_pad_r  = {1'b0, paddle_r_y};
  assign w_top    = r_y <= R + r_spd;
  assign w_bot    = r_y + r_spd >= Y_MAX;
  assign w_hit_r  = (r_x + R <= PXR) && (r_x + R + r_spd >= PXR) && (r_y >= w_pad_r) && (r_y <= w_pad_r + PH1);
  assign w_hit_l  = (r_x >= PXL + R) && (r_x <= PXL + R + r_spd) && (r_y >= w_pad_l) && (r_y <= w_pad_l + PH1);
  assign w_miss_r = r_x + R + r_spd >= X_EDGE;
  assign w_miss_l = r_x <= R + r_spd;
  assign w_spd_up = (r_spd + INC > MAXS) ? r_spd : r_spd + INC;
  assign ball_x   = r_x[9:0];
  assign ball_y   = r_y[9:0];
  assign point_l  = r_point_l;
  assign point_r  = r_point_r;
  assign busy     = r_state != IDLE;
  // next-state: rally phase sequencing and per-tick motion with independent axes
  always_comb begin
    w_state   = r_state;
    w_x       = r_x;
    w_y       = r_y;
    w_dir_l   = r_dir_l;
    w_dir_u   = r_dir_u;
    w_cnt     = r_cnt;
    w_spd     = r_spd;
    w_point_l = 1'b0;
    w_point_r = 1'b0;
    if (stop) begin
      w_state = IDLE;
      w_x     = CX;
      w_y     = CY;
      w_dir_l = 1'b0;
      w_dir_u = 1'b0;
      w_cnt   = '0;
      w_spd   = SPD;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          w_state = SERVE;
          w_cnt   = SF;
          w_spd   = SPD;
        end
        SERVE: if (frame_tick) begin
          if (r_cnt == '0) w_state = RUN;
          else w_cnt = r_cnt - 16'd1;
        end
        RUN: if (frame_tick) begin
          w_y     = r_dir_u ? (w_top ? R : r_y - r_spd) : (w_bot ? Y_MAX : r_y + r_spd);
          w_dir_u = r_dir_u ? !w_top : w_bot;
          if (r_dir_l ? w_hit_l : w_hit_r) begin
            w_x     = r_dir_l ? PXL + R : PXR - R;
            w_dir_l = !r_dir_l;
            w_spd   = w_spd_up;
          end else if (r_dir_l ? w_miss_l : w_miss_r) begin
            w_x       = r_dir_l ? R : X_MAX;
            w_point_l = !r_dir_l;
            w_point_r = r_dir_l;
            w_state   = SCORE;
          end else begin
            w_x = r_dir_l ? r_x - r_spd : r_x + r_spd;
          end
        end
        SCORE: if (frame_tick) begin
          w_state = SERVE;
          w_x     = CX;
          w_y     = CY;
          w_dir_l = !r_dir_l;
          w_cnt   = SF;
          w_spd   = SPD;
        end
        default: w_state = IDLE;
      endcase
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_x       <= CX;
      r_y       <= CY;
      r_dir_l   <= 1'b0;
      r_dir_u   <= 1'b0;
      r_cnt     <= '0;
      r_spd     <= SPD;
      r_point_l <= 1'b0;
      r_point_r <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_x       <= w_x;
      r_y       <= w_y;
      r_dir_l   <= w_dir_l;
      r_dir_u   <= w_dir_u;
      r_cnt     <= w_cnt;
      r_spd     <= w_spd;
      r_point_l <= w_point_l;
      r_point_r <= w_point_r;
    end
  end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: directed rallies checked every cycle against an edge-distance model of the ball
module tb_ball_motion_ctrl;
  localparam int SF = 3, MAXS = 4, R = 8, SPD = 2;
  logic clk = 0, reset = 1, frame_tick = 0, start = 0, stop = 0;
  logic [9:0] paddle_l_y = 0, paddle_r_y = 400;
  logic [9:0] ball_x, ball_y;
  logic point_l, point_r, busy;
  int n_chk = 0, n_err = 0;
  int m_st = 0, mx = 320, my = 240, mdx = 1, mdy = 1, mcnt = 0, mspd = SPD, mpl = 0, mpr = 0;
  bit chk_en = 1;

  ball_motion_ctrl #(.SERVE_FRAMES(SF), .MAX_SPEED(MAXS)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .stop(stop),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ball_x(ball_x), .ball_y(ball_y),
    .point_l(point_l), .point_r(point_r), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: state 0 idle, 1 serve, 2 run, 3 score; motion in terms of leading-edge distance to wall/face
  task automatic model_step(input bit rs, input bit sp, input bit st, input bit tk, input int pl, input int pr);
    int oy, lead, face, py, gap, edge_d;
    mpl = 0; mpr = 0;
    if (rs || sp) begin
      m_st = 0; mx = 320; my = 240; mdx = 1; mdy = 1; mcnt = 0; mspd = SPD;
    end else if (m_st == 0) begin
      if (st) begin m_st = 1; mcnt = SF; mspd = SPD; end
    end else if (tk) begin
      if (m_st == 1) begin
        if (mcnt == 0) m_st = 2; else mcnt--;
      end else if (m_st == 3) begin
        m_st = 1; mx = 320; my = 240; mdx = -mdx; mspd = SPD; mcnt = SF;
      end else begin
        oy = my;
        gap = (mdy > 0) ? 479 - (my + R) : my - R;
        if (gap <= mspd) begin my = (mdy > 0) ? 479 - R : R; mdy = -mdy; end
        else my += mdy * mspd;
        lead = mx + mdx * R;
        face = (mdx > 0) ? 624 : 16;
        py = (mdx > 0) ? pr : pl;
        gap = mdx * (face - lead);
        edge_d = (mdx > 0) ? 639 - lead : lead;
        if (gap >= 0 && gap <= mspd && oy >= py && oy < py + 64) begin
          mx = face - mdx * R; mdx = -mdx;
`ifdef SPEEDUP_EN
          if (mspd < MAXS) mspd++;
`endif
        end else if (edge_d <= mspd) begin
          mx = (mdx > 0) ? 639 - R : R;
          if (mdx > 0) mpl = 1; else mpr = 1;
          m_st = 3;
        end else mx += mdx * mspd;
      end
    end
  endtask

  task automatic cyc(input bit rs, input bit sp, input bit st, input bit tk);
    reset = rs; stop = sp; start = st; frame_tick = tk;
    @(posedge clk);
    model_step(rs, sp, st, tk, int'(paddle_l_y), int'(paddle_r_y));
    @(negedge clk);
    reset = 0; stop = 0; start = 0; frame_tick = 0;
  endtask

  task automatic tick();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
  endtask

  task automatic lit_xy(input string nm, input int x, input int y);
    check({nm, "_x"}, int'(ball_x), x);
    check({nm, "_y"}, int'(ball_y), y);
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) if (chk_en) begin
    check("m_ball_x", int'(ball_x), mx);
    check("m_ball_y", int'(ball_y), my);
    check("m_point_l", int'(point_l), mpl);
    check("m_point_r", int'(point_r), mpr);
    check("m_busy", int'(busy), int'(m_st != 0));
  end

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    lit_xy("reset", 320, 240);
    check("reset_busy", int'(busy), 0);
    cyc(0, 0, 1, 0);
    check("busy_after_start", int'(busy), 1);
    cyc(0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      lit_xy("serve_hold", 320, 240);
    end
    tick();
    lit_xy("run_entry", 320, 240);
    tick();
    lit_xy("first_move", 322, 242);
    for (int k = 2; k <= 149; k++) begin
      tick();
      if (k == 114) check("y_468", int'(ball_y), 468);
      if (k == 115) check("y_470", int'(ball_y), 470);
      if (k == 116) check("y_clamp_471", int'(ball_y), 471);
      if (k == 117) check("y_up_469", int'(ball_y), 469);
      if (k == 147) lit_xy("pre_hit", 614, 409);
      if (k == 148) check("hit_x_616", int'(ball_x), 616);
      if (k == 149) check("after_hit_614", int'(ball_x), 614);
    end
    cyc(0, 1, 0, 1);
    lit_xy("stop", 320, 240);
    check("stop_busy", int'(busy), 0);
    check("stop_point_l", int'(point_l), 0);
    check("stop_point_r", int'(point_r), 0);

    paddle_r_y = 0;
    paddle_l_y = 0;
    cyc(0, 0, 1, 0);
    repeat (4) tick();
    for (int k = 1; k <= 156; k++) begin
      tick();
      if (k == 148) check("miss_pass_616", int'(ball_x), 616);
      if (k == 155) check("miss_pass_630", int'(ball_x), 630);
      if (k == 156) begin
        check("miss_clamp_631", int'(ball_x), 631);
        check("point_l_pulse", int'(point_l), 1);
      end
    end
    cyc(0, 0, 0, 0);
    check("point_l_one_cycle", int'(point_l), 0);
    check("score_hold_x", int'(ball_x), 631);
    tick();
    lit_xy("recentre", 320, 240);
    repeat (4) tick();
    tick();
    lit_xy("serve_left", 318, 238);
    for (int k = 2; k <= 156; k++) begin
      tick();
      if (k == 116) check("y_top_clamp_8", int'(ball_y), 8);
      if (k == 156) begin
        check("left_clamp_8", int'(ball_x), 8);
        check("point_r_pulse", int'(point_r), 1);
      end
    end
    cyc(1, 0, 0, 1);
    lit_xy("reset_in_score", 320, 240);
    check("rst_score_busy", int'(busy), 0);
    check("rst_score_point_l", int'(point_l), 0);
    check("rst_score_point_r", int'(point_r), 0);
    cyc(0, 0, 0, 0);
    check("rst_score_point_r_next", int'(point_r), 0);

`ifdef SPEEDUP_EN
    cyc(0, 0, 1, 0);
    repeat (4) tick();
    for (int t = 0; t < 400 && m_st == 2; t++) begin
      paddle_r_y = (t < 60) ? 10'(my >= 30 ? my - 30 : 0) : 10'd1000;
      paddle_l_y = paddle_r_y;
      tick();
    end
    check("speedup_point", int'(point_l | point_r), 1);
    tick();
    repeat (4) tick();
    tick();
    check("serve_speed_dx", (int'(ball_x) > 320) ? int'(ball_x) - 320 : 320 - int'(ball_x), 2);
`endif
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
